axis_rx_hssi_pkt_buffer: RTL and testbench

AXIS_RX_HSSI_PKT_BUFFER -- requirements
Module: axis_rx_hssi_pkt_buffer

---
 rtl/axis_rx_hssi_pkt_buffer.sv | 142 ++++++++++++++
 tb/tb_axis_rx_hssi_pkt_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rx_hssi_pkt_buffer.sv
// Store-and-forward receive packet buffer for an HSSI MAC AXI-Stream port.
// Ingress has no backpressure: beats are written speculatively and either
// committed on a good tlast or rewound on error/overflow. Egress is FWFT
// with a registered output stage fed directly from the beat memory.
module axis_rx_hssi_pkt_buffer #(
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int DEPTH       = 512,
    parameter int DROP_ERR    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_tvalid,
    input  logic [TDATA_WIDTH-1:0]   s_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
    input  logic                     s_tlast,
    input  logic [TUSER_WIDTH-1:0]   s_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [TDATA_WIDTH-1:0]   m_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_tkeep,
    output logic                     m_tlast,
    output logic [TUSER_WIDTH-1:0]   m_tuser,
    output logic [31:0]              pkt_cnt,
    output logic [31:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int KW = TDATA_WIDTH / 8;
    localparam int EW = TUSER_WIDTH + KW + 1 + TDATA_WIDTH;
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_ACCEPT, ST_DISCARD} state_t;

    state_t        r_state, w_state_next;
    logic [AW:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [AW:0]   w_wr_ptr_next, w_commit_ptr_next;
    logic [EW-1:0] r_mem [DEPTH];
    logic [EW-1:0] r_m_word;
    logic          r_m_tvalid;
    logic [31:0]   r_pkt_cnt, r_drop_cnt;
    logic          w_full, w_err, w_wr_en, w_pkt_inc, w_drop_inc;
    logic          w_avail, w_load;

    // Full counts only registered pointers; a concurrent read gives no credit.
    assign w_full  = (r_wr_ptr - r_rd_ptr) == PTR_DEPTH;
    assign w_err   = (DROP_ERR != 0) && s_tuser[0];
    // Only committed entries are visible to the egress side.
    assign w_avail = (r_rd_ptr != r_commit_ptr);
    assign w_load  = w_avail && (!r_m_tvalid || m_tready);

    // Write-side FSM: decide write, commit, rewind and counter events per beat.
    always_comb begin
        w_state_next      = r_state;
        w_wr_ptr_next     = r_wr_ptr;
        w_commit_ptr_next = r_commit_ptr;
        w_wr_en           = 1'b0;
        w_pkt_inc         = 1'b0;
        w_drop_inc        = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (s_tvalid && s_tlast) w_state_next = ST_IDLE;
            end
            ST_IDLE, ST_ACCEPT: begin
                if (s_tvalid) begin
                    if (w_full) begin
                        w_wr_ptr_next = r_commit_ptr;
                        w_drop_inc    = 1'b1;
                        w_state_next  = s_tlast ? ST_IDLE : ST_DISCARD;
                    end else begin
                        w_wr_en       = 1'b1;
                        w_wr_ptr_next = r_wr_ptr + PTR_ONE;
                        if (s_tlast) begin
                            if (w_err) begin
                                w_wr_ptr_next = r_commit_ptr;
                                w_drop_inc    = 1'b1;
                            end else begin
                                w_commit_ptr_next = r_wr_ptr + PTR_ONE;
                                w_pkt_inc         = 1'b1;
                            end
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next = ST_ACCEPT;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (s_tvalid && s_tlast) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_SYNC;
        endcase
    end

    // Beat memory write port (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {s_tuser, s_tkeep, s_tlast, s_tdata};
    end

    // Write-side state, pointers and saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_SYNC;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_pkt_cnt    <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_commit_ptr <= w_commit_ptr_next;
            if (w_pkt_inc && (r_pkt_cnt != '1))   r_pkt_cnt  <= r_pkt_cnt + 32'd1;
            if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    // Egress output register: refill from memory whenever empty or consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_m_tvalid <= 1'b0;
            r_m_word   <= '0;
        end else begin
            if (w_load) begin
                r_m_word   <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                r_m_tvalid <= 1'b1;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_word[TDATA_WIDTH-1:0];
    assign m_tlast  = r_m_word[TDATA_WIDTH];
    assign m_tkeep  = r_m_word[TDATA_WIDTH+1 +: KW];
    assign m_tuser  = r_m_word[TDATA_WIDTH+1+KW +: TUSER_WIDTH];
    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_axis_rx_hssi_pkt_buffer.sv
// Bench for the RX packet buffer: directed scenarios plus randomized traffic
// checked against a queue-based packet model (good packets in order, error or
// oversize packets dropped, counters tracked as plain integers).
module tb_axis_rx_hssi_pkt_buffer;
    localparam int DW    = 32;
    localparam int UW    = 4;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int OUT_OK     = 0;
    localparam int OUT_DROP   = 1;
    localparam int OUT_IGNORE = 2;

    logic          clk;
    logic          rst_n;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic [UW-1:0] s_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_cnt;

    axis_rx_hssi_pkt_buffer #(
        .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .DEPTH(DEPTH), .DROP_ERR(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    int          exp_pkt = 0;
    int          exp_drop = 0;
    int          rx_beats = 0;
    int          rdy_mode = 0;   // 0 = always ready, 1 = never, 2 = random
    int          pkt_id = 0;
    bit          prev_stall = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_word(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                              input logic l, input logic [UW-1:0] u);
        return {23'd0, u, k, l, d};
    endfunction

    // Egress monitor: every presented beat must equal the model's head beat.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check_val("hold_valid", 64'(m_tvalid), 64'd1);
                if (m_tvalid) begin
                    check_val("q_nonempty", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        check_val("beat", pack_word(m_tdata, m_tkeep, m_tlast, m_tuser), exp_q[0]);
                        if (m_tready) void'(exp_q.pop_front());
                    end
                    if (m_tready) rx_beats++;
                end
                prev_stall = m_tvalid && !m_tready;
            end
        end
    end

    // Egress ready driver.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'b0;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int len, input bit err, input int outcome, input bit throttle);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        int            waited;
        waited = 0;
        if (throttle) begin
            while ((exp_q.size() + len > DEPTH - 2) && (waited < 1000)) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (waited >= 1000) check_val("throttle_timeout", 64'(waited), 64'd0);
        end
        pkt_id++;
        $display("pkt %0d len=%0d err=%0d outcome=%0d", pkt_id, len, err, outcome);
        for (int i = 0; i < len; i++) begin
            d = $urandom;
            k = KW'($urandom);
            u = UW'($urandom);
            l = (i == len - 1);
            if (l) u[0] = err;
            s_tvalid = 1'b1;
            s_tdata  = d;
            s_tkeep  = k;
            s_tlast  = l;
            s_tuser  = u;
            if (outcome == OUT_OK) exp_q.push_back(pack_word(d, k, l, u));
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (outcome == OUT_OK) exp_pkt++;
        else if (outcome == OUT_DROP) exp_drop++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((exp_q.size() != 0) || m_tvalid) && (n < 2000)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
        check_val({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    int rx0;

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        exp_q.delete();
        idle(3);
        check_val("rst_tvalid", 64'(m_tvalid), 64'd0);
        check_val("rst_word", pack_word(m_tdata, m_tkeep, m_tlast, m_tuser), 64'd0);
        check_counts("rst");
        rst_n = 1'b1;

        // Tail beat absorbed by SYNC, then a 4-beat packet with latency check.
        send_pkt(1, 1'b0, OUT_IGNORE, 1'b0);
        rx0 = rx_beats;
        send_pkt(4, 1'b0, OUT_OK, 1'b0);
        @(negedge clk);
        check_val("lat_edge1", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        check_val("lat_edge2", 64'(m_tvalid), 64'd1);
        @(posedge clk);
        #1;
        drain();
        check_val("first_rx", 64'(rx_beats - rx0), 64'd4);
        check_counts("first");

        // Errored packet is discarded; the next good one goes through.
        send_pkt(3, 1'b1, OUT_DROP, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("err_no_valid", 64'(m_tvalid), 64'd0);
        end
        @(posedge clk);
        #1;
        check_counts("err");
        send_pkt(5, 1'b0, OUT_OK, 1'b0);
        drain();
        check_counts("after_err");

        // Two 10-beat packets with egress stalled: second overflows.
        rdy_mode = 1;
        idle(2);
        rx0 = rx_beats;
        send_pkt(10, 1'b0, OUT_OK, 1'b0);
        send_pkt(10, 1'b0, OUT_DROP, 1'b0);
        idle(4);
        check_counts("ovf");
        check_val("ovf_valid", 64'(m_tvalid), 64'd1);
        rdy_mode = 0;
        drain();
        check_val("ovf_rx", 64'(rx_beats - rx0), 64'd10);

        // Oversize packet dropped, following 2-beat packet delivered.
        rx0 = rx_beats;
        send_pkt(20, 1'b0, OUT_DROP, 1'b0);
        send_pkt(2, 1'b0, OUT_OK, 1'b0);
        drain();
        check_val("big_rx", 64'(rx_beats - rx0), 64'd2);
        check_counts("big");

        // Random ready with back-to-back single beats, then mixed packets.
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) send_pkt(1, 1'b0, OUT_OK, 1'b1);
        for (int i = 0; i < 60; i++) begin
            int len;
            bit err;
            len = $urandom_range(1, 6);
            err = ($urandom_range(0, 3) == 0);
            send_pkt(len, err, err ? OUT_DROP : OUT_OK, 1'b1);
        end
        drain();
        check_counts("rand");

        // Reset asserted and released in the middle of a packet.
        rdy_mode = 1;
        idle(2);
        send_pkt(3, 1'b0, OUT_OK, 1'b0);
        idle(3);
        check_val("pre_rst_valid", 64'(m_tvalid), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rst_n = 1'b0;
                exp_q.delete();
                exp_pkt  = 0;
                exp_drop = 0;
            end
            if (i == 5) begin
                check_val("mid_rst_valid", 64'(m_tvalid), 64'd0);
                check_counts("mid_rst");
                rst_n = 1'b1;
            end
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tkeep  = '1;
            s_tlast  = (i == 7);
            s_tuser  = '0;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("tail_no_valid", 64'(m_tvalid), 64'd0);
        end
        @(posedge clk);
        #1;
        check_counts("tail");
        send_pkt(4, 1'b0, OUT_OK, 1'b0);
        drain();
        check_counts("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
